imem_loader: RTL and testbench

- Writer side of the instruction-memory interface that iFetch reads.
- Accepts a valid/ready stream of 32-bit instruction words, writes them to consecutive imem word addresses from 0, and holds the pipeline in reset until the image is loaded.
- Sits between the bench/host loader and the iFetch instruction memory write port.

---
 rtl/arm_loader_pkg.sv | 18 +
 rtl/imem_loader_sum.sv | 35 +++
 rtl/imem_loader.sv | 195 +++++++++++++++++++
 tb/tb_imem_loader.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/arm_loader_pkg.sv
// Shared definitions for the instruction-memory loader: state encoding and default word width.
// Honours an externally supplied `INSTR_LEN define, falling back to 32 bits.
`ifndef INSTR_LEN
`define INSTR_LEN 32
`endif

package arm_loader_pkg;

   localparam int DEF_INSTR_LEN = `INSTR_LEN;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      DONE  = 2'd2,
      ERROR = 2'd3
   } loader_state_t;

endpackage

// File: rtl/imem_loader_sum.sv
// Running modulo-2^W sum of accepted image words, used only when IMEM_LOADER_CHECKSUM_EN is defined.
// sum_next exposes the total including the word being accepted, so the final compare needs no extra cycle.
module imem_loader_sum
   import arm_loader_pkg::*;
#(
   parameter int W = DEF_INSTR_LEN
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         clear,
   input  logic         acc,
   input  logic [W-1:0] data,
   output logic [W-1:0] sum,
   output logic [W-1:0] sum_next
);

   logic [W-1:0] sum_r;

   assign sum_next = sum_r + data;
   assign sum      = sum_r;

   // accumulator register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sum_r <= {W{1'b0}};
      end else if (clear) begin
         sum_r <= {W{1'b0}};
      end else if (acc) begin
         sum_r <= sum_next;
      end else begin
         sum_r <= sum_r;
      end
   end

endmodule

// File: rtl/imem_loader.sv
// Streams instruction words into imem from address 0 and holds the pipeline until the image is in.
// Optional checksum verification is enabled with the IMEM_LOADER_CHECKSUM_EN macro.
module imem_loader
   import arm_loader_pkg::*;
#(
   parameter int SIZE      = 64,
   parameter int INSTR_LEN = DEF_INSTR_LEN,
   parameter int AW        = $clog2(SIZE)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [INSTR_LEN-1:0] in_data,
   input  logic                 in_last,
   output logic                 imem_we,
   output logic [AW-1:0]        imem_addr,
   output logic [INSTR_LEN-1:0] imem_wdata,
   output logic                 cpu_hold,
   output logic                 done,
   output logic                 error,
`ifdef IMEM_LOADER_CHECKSUM_EN
   input  logic [INSTR_LEN-1:0] exp_sum,
   output logic [INSTR_LEN-1:0] sum,
   output logic                 sum_ok,
`endif
   output logic [AW:0]          word_count
);

   localparam logic [AW:0] LAST_IDX = (AW+1)'(SIZE - 1);
   localparam logic [AW:0] ONE      = {{AW{1'b0}}, 1'b1};

   loader_state_t        state_r, state_next_s;
   logic                 in_ready_r, in_ready_s;
   logic                 imem_we_r, imem_we_s;
   logic [AW-1:0]        imem_addr_r, imem_addr_s;
   logic [INSTR_LEN-1:0] imem_wdata_r, imem_wdata_s;
   logic                 cpu_hold_r, cpu_hold_s;
   logic                 done_r, done_s;
   logic                 error_r, error_s;
   logic [AW:0]          word_count_r, word_count_s;
   logic                 launch_s;
   logic                 accept_s;

   // start only counts outside LOAD; in LOAD it is ignored
   assign launch_s = start && (state_r != LOAD);
   assign accept_s = (state_r == LOAD) && in_valid && in_ready_r;

`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [INSTR_LEN-1:0] sum_next_s;
   logic                 sum_ok_r, sum_ok_s;

   imem_loader_sum #(.W(INSTR_LEN)) u_sum (
      .clk      (clk),
      .reset    (reset),
      .clear    (launch_s),
      .acc      (accept_s),
      .data     (in_data),
      .sum      (sum),
      .sum_next (sum_next_s)
   );

   assign sum_ok = sum_ok_r;
`endif

   // state register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // next state and next registered output values
   always_comb begin
      state_next_s = state_r;
      in_ready_s   = 1'b0;
      imem_we_s    = 1'b0;
      imem_addr_s  = imem_addr_r;
      imem_wdata_s = imem_wdata_r;
      cpu_hold_s   = cpu_hold_r;
      done_s       = done_r;
      error_s      = error_r;
      word_count_s = word_count_r;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum_ok_s     = sum_ok_r;
`endif
      case (state_r)
         LOAD: begin
            in_ready_s = 1'b1;
            if (accept_s) begin
               imem_we_s    = 1'b1;
               imem_addr_s  = word_count_r[AW-1:0];
               imem_wdata_s = in_data;
               word_count_s = word_count_r + ONE;
               if (in_last) begin
                  in_ready_s = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                  if (sum_next_s == exp_sum) begin
                     state_next_s = DONE;
                     sum_ok_s     = 1'b1;
                  end else begin
                     state_next_s = ERROR;
                     sum_ok_s     = 1'b0;
                     error_s      = 1'b1;
                  end
`else
                  state_next_s = DONE;
`endif
               end else if (word_count_r == LAST_IDX) begin
                  // the word that fills the last slot still lands; anything more is overflow
                  in_ready_s   = 1'b0;
                  state_next_s = ERROR;
                  error_s      = 1'b1;
               end else begin
                  state_next_s = LOAD;
               end
            end else begin
               state_next_s = LOAD;
            end
         end
         DONE: begin
            // release lags the final write pulse by one cycle
            cpu_hold_s = 1'b0;
            done_s     = 1'b1;
         end
         ERROR: begin
            cpu_hold_s = 1'b1;
            error_s    = 1'b1;
         end
         IDLE: begin
            cpu_hold_s = 1'b1;
         end
         default: begin
            state_next_s = IDLE;
            cpu_hold_s   = 1'b1;
         end
      endcase

      if (launch_s) begin
         state_next_s = LOAD;
         in_ready_s   = 1'b1;
         cpu_hold_s   = 1'b1;
         done_s       = 1'b0;
         error_s      = 1'b0;
         word_count_s = {(AW+1){1'b0}};
`ifdef IMEM_LOADER_CHECKSUM_EN
         sum_ok_s     = 1'b0;
`endif
      end else begin
         state_next_s = state_next_s;
      end
   end

   // registered outputs
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         in_ready_r   <= 1'b0;
         imem_we_r    <= 1'b0;
         imem_addr_r  <= {AW{1'b0}};
         imem_wdata_r <= {INSTR_LEN{1'b0}};
         cpu_hold_r   <= 1'b1;
         done_r       <= 1'b0;
         error_r      <= 1'b0;
         word_count_r <= {(AW+1){1'b0}};
`ifdef IMEM_LOADER_CHECKSUM_EN
         sum_ok_r     <= 1'b0;
`endif
      end else begin
         in_ready_r   <= in_ready_s;
         imem_we_r    <= imem_we_s;
         imem_addr_r  <= imem_addr_s;
         imem_wdata_r <= imem_wdata_s;
         cpu_hold_r   <= cpu_hold_s;
         done_r       <= done_s;
         error_r      <= error_s;
         word_count_r <= word_count_s;
`ifdef IMEM_LOADER_CHECKSUM_EN
         sum_ok_r     <= sum_ok_s;
`endif
      end
   end

   assign in_ready   = in_ready_r;
   assign imem_we    = imem_we_r;
   assign imem_addr  = imem_addr_r;
   assign imem_wdata = imem_wdata_r;
   assign cpu_hold   = cpu_hold_r;
   assign done       = done_r;
   assign error      = error_r;
   assign word_count = word_count_r;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader (SIZE=4) with a write scoreboard and a model of imem contents.
// Checksum steps are included when IMEM_LOADER_CHECKSUM_EN is defined.
module tb_imem_loader;
   import arm_loader_pkg::*;

   localparam int SIZE = 4;
   localparam int W    = 32;
   localparam int AW   = $clog2(SIZE);

   logic          clk = 1'b0;
   logic          reset, start, in_valid, in_ready, in_last;
   logic [W-1:0]  in_data, imem_wdata;
   logic          imem_we, cpu_hold, done, error;
   logic [AW-1:0] imem_addr;
   logic [AW:0]   word_count;
`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [W-1:0]  exp_sum, sum;
   logic          sum_ok;
`endif

   int            checks = 0;
   int            errors = 0;
   logic [AW-1:0] addr_q[$];
   logic [W-1:0]  data_q[$];
   logic [W-1:0]  mem [SIZE];
   logic [AW-1:0] next_addr;

   imem_loader #(.SIZE(SIZE), .INSTR_LEN(W)) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .in_last    (in_last),
      .imem_we    (imem_we),
      .imem_addr  (imem_addr),
      .imem_wdata (imem_wdata),
      .cpu_hold   (cpu_hold),
      .done       (done),
      .error      (error),
`ifdef IMEM_LOADER_CHECKSUM_EN
      .exp_sum    (exp_sum),
      .sum        (sum),
      .sum_ok     (sum_ok),
`endif
      .word_count (word_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // scoreboard: every write pulse must match the next expected beat
   always @(negedge clk) begin
      if (reset === 1'b1 && imem_we === 1'b1) begin
         chk("write_expected", 64'(addr_q.size() != 0), 64'd1);
         if (addr_q.size() != 0) begin
            chk("write_addr", 64'(imem_addr), 64'(addr_q.pop_front()));
            chk("write_data", 64'(imem_wdata), 64'(data_q.pop_front()));
         end
         mem[imem_addr] = imem_wdata;
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick(1);
      start = 1'b0;
      next_addr = '0;
   endtask

   task automatic send(input logic [W-1:0] d, input logic last);
      bit acc;
      acc = 1'b0;
      in_valid = 1'b1;
      in_data  = d;
      in_last  = last;
      for (int i = 0; i < 20 && !acc; i++) begin
         if (in_ready === 1'b1) begin
            addr_q.push_back(next_addr);
            data_q.push_back(d);
            next_addr++;
            acc = 1'b1;
         end
         tick(1);
      end
      if (!acc) chk("accept_timeout", 64'(in_ready), 64'd1);
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic check_done(input int wc);
      chk("done", 64'(done), 64'd1);
      chk("cpu_hold_released", 64'(cpu_hold), 64'd0);
      chk("no_error", 64'(error), 64'd0);
      chk("ready_low_done", 64'(in_ready), 64'd0);
      chk("word_count", 64'(word_count), 64'(wc));
      chk("all_writes_seen", 64'(addr_q.size()), 64'd0);
   endtask

   task automatic check_reset_vals();
      chk("rst_in_ready", 64'(in_ready), 64'd0);
      chk("rst_imem_we", 64'(imem_we), 64'd0);
      chk("rst_imem_addr", 64'(imem_addr), 64'd0);
      chk("rst_imem_wdata", 64'(imem_wdata), 64'd0);
      chk("rst_cpu_hold", 64'(cpu_hold), 64'd1);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_error", 64'(error), 64'd0);
      chk("rst_word_count", 64'(word_count), 64'd0);
   endtask

   initial begin
      reset = 1'b0; start = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = '0;
      next_addr = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      exp_sum = '0;
`endif
      tick(3);
      check_reset_vals();
      reset = 1'b1;
      tick(1);
      chk("idle_no_ready", 64'(in_ready), 64'd0);

      // basic three-word image
      pulse_start();
      chk("load_ready", 64'(in_ready), 64'd1);
      chk("load_hold", 64'(cpu_hold), 64'd1);
      send(32'hF84402C9, 1'b0);
      send(32'h8B09026A, 1'b0);
      send(32'hCB0A028B, 1'b1);
      chk("hold_during_last_write", 64'(cpu_hold), 64'd1);
      chk("done_not_early", 64'(done), 64'd0);
      tick(1);
      check_done(3);
      chk("fetch_pc0", 64'(mem[0]), 64'hF84402C9);
      chk("fetch_pc4", 64'(mem[1]), 64'h8B09026A);
      chk("fetch_pc8", 64'(mem[2]), 64'hCB0A028B);

      // gaps between beats, plus start during LOAD
      pulse_start();
      chk("restart_clears_done", 64'(done), 64'd0);
      send(32'hF84402C9, 1'b0);
      start = 1'b1;
      tick(1);
      start = 1'b0;
      tick(1);
      chk("start_ignored_wc", 64'(word_count), 64'd1);
      chk("start_ignored_ready", 64'(in_ready), 64'd1);
      send(32'h8B09026A, 1'b0);
      tick(2);
      chk("gap_wc", 64'(word_count), 64'd2);
      send(32'hCB0A028B, 1'b1);
      tick(1);
      check_done(3);

      // overflow: four words fill memory, fifth is refused
      pulse_start();
      send(32'h00000011, 1'b0);
      send(32'h00000022, 1'b0);
      send(32'h00000033, 1'b0);
      send(32'h00000044, 1'b0);
      chk("ovf_error", 64'(error), 64'd1);
      chk("ovf_ready", 64'(in_ready), 64'd0);
      in_valid = 1'b1;
      in_data  = 32'h00000055;
      tick(5);
      in_valid = 1'b0;
      chk("ovf_error_hold", 64'(error), 64'd1);
      chk("ovf_ready_hold", 64'(in_ready), 64'd0);
      chk("ovf_cpu_hold", 64'(cpu_hold), 64'd1);
      chk("ovf_done", 64'(done), 64'd0);
      chk("ovf_word_count", 64'(word_count), 64'd4);
      chk("ovf_mem3", 64'(mem[3]), 64'h00000044);

      // reset mid-load, then a clean reload
      pulse_start();
      chk("restart_clears_error", 64'(error), 64'd0);
      send(32'hA0000001, 1'b0);
      send(32'hA0000002, 1'b0);
      tick(1);
      reset = 1'b0;
      #1;
      check_reset_vals();
      tick(1);
      reset = 1'b1;
      tick(1);
      pulse_start();
      send(32'hF84402C9, 1'b0);
      send(32'h8B09026A, 1'b0);
      send(32'hCB0A028B, 1'b1);
      tick(1);
      check_done(3);
      chk("reload_pc4", 64'(mem[1]), 64'h8B09026A);

      // start in DONE with a one-word image
      start = 1'b1;
      tick(1);
      start = 1'b0;
      next_addr = '0;
      chk("redo_hold", 64'(cpu_hold), 64'd1);
      chk("redo_done_clr", 64'(done), 64'd0);
      chk("redo_wc_clr", 64'(word_count), 64'd0);
      send(32'hD65F03C0, 1'b1);
      tick(1);
      check_done(1);
      chk("redo_pc0", 64'(mem[0]), 64'hD65F03C0);

      // last word exactly at the top address is legal
      pulse_start();
      send(32'h00000101, 1'b0);
      send(32'h00000202, 1'b0);
      send(32'h00000303, 1'b0);
      send(32'h00000404, 1'b1);
      tick(1);
      check_done(4);
      chk("edge_pc12", 64'(mem[3]), 64'h00000404);

`ifdef IMEM_LOADER_CHECKSUM_EN
      exp_sum = 32'd6;
      pulse_start();
      send(32'd1, 1'b0);
      send(32'd2, 1'b0);
      send(32'd3, 1'b1);
      tick(1);
      check_done(3);
      chk("sum_ok_good", 64'(sum_ok), 64'd1);
      chk("sum_value", 64'(sum), 64'd6);
      exp_sum = 32'd7;
      pulse_start();
      send(32'd1, 1'b0);
      send(32'd2, 1'b0);
      send(32'd3, 1'b1);
      tick(1);
      chk("sum_bad_error", 64'(error), 64'd1);
      chk("sum_bad_hold", 64'(cpu_hold), 64'd1);
      chk("sum_bad_done", 64'(done), 64'd0);
      chk("sum_ok_bad", 64'(sum_ok), 64'd0);
`endif

      tick(2);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
